// File: rtl/inv_srl16.sv
// inv_srl16: 16-tap shift register with dynamic tap address and optional D/CE inversion
// Ports: clk, rst (sync, active-high); D serial in; CE shift enable; A tap address;
//        Q = tap A; Q_VALID = tap A holds data shifted in since reset; FULL = 16+ shifts.
// Macro INV_SRL16_CASCADE_EN adds Q15 (= tap 15) for chaining into the next stage's D.
module inv_srl16 #(
    parameter logic        INV_D  = 1'b0,
    parameter logic        INV_CE = 1'b0,
    parameter logic [15:0] INIT   = 16'h0000
) (
    input  logic       clk,
    input  logic       rst,
    (* invertible_pin = "INV_D" *)
    input  logic       D,
    (* invertible_pin = "INV_CE" *)
    input  logic       CE,
    input  logic [3:0] A,
    output logic       Q,
    output logic       Q_VALID,
    output logic       FULL
`ifdef INV_SRL16_CASCADE_EN
    ,
    output logic       Q15
`endif
);
    logic [15:0] sr;
    logic [4:0]  fill;
    logic        d_eff;
    logic        ce_eff;
    always_comb begin
        d_eff   = D ^ INV_D;
        ce_eff  = CE ^ INV_CE;
        Q       = sr[A];
        Q_VALID = fill > {1'b0, A};
        FULL    = fill == 5'd16;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sr   <= INIT;
            fill <= '0;
        end else if (ce_eff) begin
            sr   <= {sr[14:0], d_eff};
            fill <= FULL ? fill : fill + 5'd1;
        end
    end
`ifdef INV_SRL16_CASCADE_EN
    assign Q15 = sr[15];
`endif
endmodule

// File: tb/tb_inv_srl16.sv
// tb_inv_srl16: table, directed and randomized checks of inv_srl16 against a queue model
module tb_inv_srl16;
    localparam logic [15:0] INITV = 16'hA5A5;
    logic clk, rst;
    logic d0, ce0, q0, v0, f0;
    logic d1, ce1, q1, v1, f1;
    logic [3:0] a0, a1;
    int n_cmp = 0;
    int n_err = 0;

`ifdef INV_SRL16_CASCADE_EN
    logic cd, cce, cq0, cv0, cf0, cq1, cv1, cf1, c15_0, c15_1;
    logic [3:0] ca;
    inv_srl16 u0 (.clk(clk), .rst(rst), .D(d0), .CE(ce0), .A(a0), .Q(q0), .Q_VALID(v0), .FULL(f0), .Q15());
    inv_srl16 #(.INV_D(1'b1), .INV_CE(1'b1), .INIT(INITV)) u1 (.clk(clk), .rst(rst), .D(d1), .CE(ce1), .A(a1), .Q(q1), .Q_VALID(v1), .FULL(f1), .Q15());
    inv_srl16 c0 (.clk(clk), .rst(rst), .D(cd), .CE(cce), .A(ca), .Q(cq0), .Q_VALID(cv0), .FULL(cf0), .Q15(c15_0));
    inv_srl16 c1 (.clk(clk), .rst(rst), .D(c15_0), .CE(cce), .A(ca), .Q(cq1), .Q_VALID(cv1), .FULL(cf1), .Q15(c15_1));
`else
    inv_srl16 #(.INIT(INITV)) u0 (.clk(clk), .rst(rst), .D(d0), .CE(ce0), .A(a0), .Q(q0), .Q_VALID(v0), .FULL(f0));
    inv_srl16 #(.INV_D(1'b1), .INV_CE(1'b1), .INIT(INITV)) u1 (.clk(clk), .rst(rst), .D(d1), .CE(ce1), .A(a1), .Q(q1), .Q_VALID(v1), .FULL(f1));
`endif

`ifdef INV_SRL16_CASCADE_EN
    defparam u0.INIT = INITV;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       d;
        logic       ce;
        logic [3:0] a;
        logic       q;
        logic       qv;
        logic       full;
    } vec_t;
    vec_t tv[$];

    task automatic add(input logic r, input logic d, input logic ce, input logic [3:0] a,
                       input logic q, input logic qv, input logic full);
        tv.push_back('{r, d, ce, a, q, qv, full});
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic tap(input bit h[$], input int n, input int i);
        return (i < n) ? h[i] : INITV[i - n];
    endfunction

    bit h0[$];
    bit h1[$];
    int n0, n1;
    bit junk;

    initial begin
        rst = 1'b1; d0 = 0; ce0 = 0; a0 = 0; d1 = 0; ce1 = 0; a1 = 0;
`ifdef INV_SRL16_CASCADE_EN
        cd = 0; cce = 0; ca = 0;
`endif
        // reset then address sweep with shifting disabled
        add(1, 0, 0, 0, INITV[0], 0, 0);
        for (int a = 1; a < 16; a++) add(0, 0, 0, 4'(a), INITV[a], 0, 0);
        // shift 1,0,1,1 then read taps 0..4
        add(1, 0, 0, 0, INITV[0], 0, 0);
        add(0, 1, 1, 0, 1, 1, 0);
        add(0, 0, 1, 0, 0, 1, 0);
        add(0, 1, 1, 0, 1, 1, 0);
        add(0, 1, 1, 0, 1, 1, 0);
        add(0, 0, 0, 0, 1, 1, 0);
        add(0, 0, 0, 1, 1, 1, 0);
        add(0, 0, 0, 2, 0, 1, 0);
        add(0, 0, 0, 3, 1, 1, 0);
        add(0, 0, 0, 4, INITV[0], 0, 0);
        for (int i = 0; i < tv.size(); i++) begin
            rst = tv[i].rst; d0 = tv[i].d; ce0 = tv[i].ce; a0 = tv[i].a;
            step();
            chk($sformatf("tbl%0d_q", i), q0, tv[i].q);
            chk($sformatf("tbl%0d_qv", i), v0, tv[i].qv);
            chk($sformatf("tbl%0d_full", i), f0, tv[i].full);
        end

        // inverted pins: CE=0 means shift, D=0 means shift in 1
        rst = 1; ce1 = 1; d1 = 0; step();
        rst = 0; ce1 = 0;
        repeat (3) step();
        for (int pass = 0; pass < 2; pass++) begin
            for (int a = 0; a < 3; a++) begin
                a1 = 4'(a); #1;
                chk($sformatf("inv_tap%0d_p%0d", a, pass), q1, 1);
                chk($sformatf("inv_qv%0d_p%0d", a, pass), v1, 1);
            end
            a1 = 3; #1;
            chk($sformatf("inv_qv3_p%0d", pass), v1, 0);
            chk($sformatf("inv_tap3_p%0d", pass), q1, INITV[0]);
            if (pass == 0) begin
                ce1 = 1;
                repeat (2) step();
            end
        end

        // saturation over 20 shifts
        rst = 1; step();
        rst = 0; ce0 = 1; a0 = 0;
        for (int k = 1; k <= 20; k++) begin
            d0 = 1'($urandom); step();
            chk($sformatf("sat_full_e%0d", k), f0, k >= 16);
            chk($sformatf("sat_tap0_e%0d", k), q0, d0);
        end
        a0 = 15; #1;
        chk("sat_qv15", v0, 1);

        // reset beats shift mid-fill
        rst = 1; step();
        rst = 0; ce0 = 1; d0 = 0;
        repeat (7) step();
        rst = 1; ce0 = 1; d0 = 1; step();
        rst = 0; ce0 = 0;
        chk("rstw_full", f0, 0);
        for (int a = 0; a < 16; a++) begin
            a0 = 4'(a); #1;
            chk($sformatf("rstw_q%0d", a), q0, INITV[a]);
            chk($sformatf("rstw_qv%0d", a), v0, 0);
        end

`ifdef INV_SRL16_CASCADE_EN
        rst = 1; step();
        rst = 0; cce = 1; cd = 1; step();
        cd = 0;
        for (int e = 2; e <= 17; e++) begin
            step();
            if (e == 15) chk("casc_q15_e15", c15_0, 0);
            if (e == 16) chk("casc_q15_e16", c15_0, 1);
            if (e == 16) chk("casc_c1tap0_e16", cq1, 0);
        end
        chk("casc_c1tap0_e17", cq1, 1);
        cce = 0;
`endif

        // randomized against queue model
        for (int i = 0; i < 400; i++) begin
            rst = (i == 0) || ($urandom_range(0, 39) == 0);
            d0 = 1'($urandom); ce0 = 1'($urandom); a0 = 4'($urandom);
            d1 = 1'($urandom); ce1 = 1'($urandom); a1 = 4'($urandom);
            step();
            if (rst) begin
                h0.delete(); h1.delete(); n0 = 0; n1 = 0;
            end else begin
                if (ce0) begin h0.push_front(d0); n0++; end
                if (!ce1) begin h1.push_front(!d1); n1++; end
                if (h0.size() > 16) junk = h0.pop_back();
                if (h1.size() > 16) junk = h1.pop_back();
            end
            chk($sformatf("rnd%0d_q0", i), q0, tap(h0, n0, a0));
            chk($sformatf("rnd%0d_qv0", i), v0, n0 > a0);
            chk($sformatf("rnd%0d_f0", i), f0, n0 >= 16);
            chk($sformatf("rnd%0d_q1", i), q1, tap(h1, n1, a1));
            chk($sformatf("rnd%0d_qv1", i), v1, n1 > a1);
            chk($sformatf("rnd%0d_f1", i), f1, n1 >= 16);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/inv_srl16.md
INV_SRL16 -- requirements
Module: inv_srl16

Interface
REQ-001 Parameter INV_D, default 1'b0, inverts data input D before use when 1.
REQ-002 Parameter INV_CE, default 1'b0, inverts clock enable CE before use when 1.
REQ-003 Parameter INIT, default 16'h0000, shift-register contents after reset; bit i is tap i.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 D  input  1  serial data in; marked invertible_pin="INV_D".
REQ-007 CE  input  1  shift enable; marked invertible_pin="INV_CE".
REQ-008 A  input  4  dynamic tap address, 0..15.
REQ-009 Q  output  1  selected tap value.
REQ-010 Q_VALID  output  1  selected tap holds data shifted in since last reset.
REQ-011 FULL  output  1  16 or more shifts since last reset.

Function
REQ-012 d_eff = D XOR INV_D; ce_eff = CE XOR INV_CE; only d_eff and ce_eff are used internally.
REQ-013 State: 16-bit register sr, 5-bit fill counter fill.
REQ-014 Rising clk with rst=0, ce_eff=1: sr <= {sr[14:0], d_eff}; fill <= fill+1 saturating at 16.
REQ-015 Rising clk with rst=0, ce_eff=0: sr and fill hold.
REQ-016 Q = sr[A], combinational from A and sr; zero-cycle latency from A, one-cycle latency from D to tap 0.
REQ-017 Data written at edge k appears at tap n after edge k+n, given ce_eff=1 on every edge between.
REQ-018 Q_VALID = (fill > A), combinational.
REQ-019 FULL = (fill == 16), combinational.
REQ-020 fill saturates at 16: further shifts keep fill=16, FULL=1, and Q_VALID=1 for all A.
REQ-021 A changes during shift: Q reflects the new A against the current sr, with no glitch-hold or registered address.
REQ-022 Simultaneous rst=1 and ce_eff=1: reset wins; no shift and no fill increment.
REQ-023 No X propagation from INIT: all state is defined after the first reset edge.

Reset
REQ-024 rst=1 at a rising clk edge: sr <= INIT, fill <= 0; takes effect that edge regardless of CE, D or an in-progress fill.
REQ-025 Outputs after reset: Q = INIT[A], Q_VALID = 0, FULL = 0.
REQ-026 Before the first reset edge, state is undefined; the bench does not check outputs.

Configuration
REQ-027 Macro INV_SRL16_CASCADE_EN.
REQ-028 Defined: adds output port Q15 (1 bit, direction output, declared after FULL), Q15 = sr[15] combinational, for chaining into the D of the next inv_srl16; reset value INIT[15].
REQ-029 Undefined: port Q15 is absent; all other behaviour is identical.

Verification
REQ-030 INIT=16'hA5A5; assert rst 1 cycle; sweep A 0..15 -> Q equals INIT[A] each step, Q_VALID=0, FULL=0.
REQ-031 INV_D=0, INV_CE=0; after reset shift D=1,0,1,1 with CE=1 for 4 edges -> A=0..3 gives Q=1,1,0,1; Q_VALID=1 for A<4 and 0 for A=4.
REQ-032 INV_D=1, INV_CE=1; after reset drive CE=0, D=0 for 3 edges -> taps 0..2 = 1, fill=3; then CE=1 for 2 edges -> sr and fill unchanged.
REQ-033 Shift 20 edges with CE=1 -> FULL=1 from edge 16 onward; fill stays 16; Q_VALID=1 for A=15.
REQ-034 Mid-fill (fill=7): drive rst=1 and CE=1 on the same edge -> next cycle sr=INIT, FULL=0, Q_VALID=0 for A=0.
REQ-035 INV_SRL16_CASCADE_EN defined; chain two instances Q15->D; shift 17 edges of pattern 1 then 0s -> first instance Q15 rises after edge 16; second instance tap 0 = 1 after edge 17.
